// File: rtl/com_config_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : com_cfg_shift_pkg
//  Brief    : Shared types and sizes for the configuration-chain shifter.
//  Revision : 1.0
// ============================================================================
package com_cfg_shift_pkg;

    localparam int CFG_WORD_W = 16;
    localparam int CFG_WORDS  = 256;
    localparam int CFG_HP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOAD = 2'd3
    } cfg_shift_state_t;

endpackage
`default_nettype wire

// File: rtl/com_config_shift_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : com_config_shift_ctrl_if
//  Brief    : Configuration-chain pin bundle between shifter and DUT chain.
//  Revision : 1.0
// ============================================================================
interface com_config_shift_ctrl_if;

    logic fw_config_clk;
    logic fw_config_in;
    logic fw_config_load;
    logic fw_config_out;

    modport master (
        output fw_config_clk,
        output fw_config_in,
        output fw_config_load,
        input  fw_config_out
    );

    modport slave (
        input  fw_config_clk,
        input  fw_config_in,
        input  fw_config_load,
        output fw_config_out
    );

endinterface
`default_nettype wire

// File: rtl/com_config_shift_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : com_tick_div
//  Brief    : Phase-length down-counter; o_tick marks the last cycle of a phase.
//  Revision : 1.0
// ============================================================================
module com_tick_div #(
    parameter int DIV_W = 9
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic [DIV_W-1:0] i_load_val,
    output logic                  o_tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Loading val-1 makes a phase last exactly val cycles including the load cycle's successor.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val - DIV_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/com_config_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : com_config_shift_ctrl
//  Brief    : Shifts the config word array into the DUT chain and captures
//             the returning bits into a readback array.
//  Revision : 1.0
// ============================================================================
module com_config_shift_ctrl
    import com_cfg_shift_pkg::*;
#(
    parameter int WORDS  = CFG_WORDS,
    parameter int WORD_W = CFG_WORD_W,
    parameter int CNT_W  = $clog2(WORDS*WORD_W)+1
) (
    input  wire logic                          fw_axi_clk,
    input  wire logic                          fw_rst_n,
    input  wire logic                          op_code_w_reset,
    input  wire logic                          op_code_w_execute,
    input  wire logic                          op_code_w_status_clear,
    input  wire logic [WORDS-1:0][WORD_W-1:0]  cfg_words,
    input  wire logic [CNT_W-1:0]              bit_count,
    input  wire logic [CFG_HP_W-1:0]           half_period,
    input  wire logic [7:0]                    rd_addr,
    output logic      [WORD_W-1:0]             rd_data,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun,
    com_config_shift_ctrl_if.master            cfg_if
);

    localparam int WA_W  = $clog2(WORDS);
    localparam int BI_W  = $clog2(WORD_W);
    localparam int DIV_W = CFG_HP_W + 1;

    cfg_shift_state_t              state_q, state_d;
    logic [CNT_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              n_q, n_d;
    logic [CFG_HP_W-1:0]           h_q, h_d;
    logic                          done_q, done_d;
    logic                          ovr_q, ovr_d;
    logic                          busy_q, busy_d;
    logic                          cclk_q, cclk_d;
    logic                          cin_q, cin_d;
    logic                          cload_q, cload_d;
    logic [WORDS-1:0][WORD_W-1:0]  cap_q, cap_d;

    logic                          w_tick;
    logic                          w_div_load;
    logic [DIV_W-1:0]              w_div_val;
    logic [WA_W-1:0]               w_cur_word;
    logic [BI_W-1:0]               w_cur_bit;
    logic [WA_W-1:0]               w_nxt_word;
    logic [BI_W-1:0]               w_nxt_bit;
    logic [WORD_W-1:0]             w_nxt_cfg;

    // Bit i lives at word i/WORD_W, MSB first within the word.
    assign w_cur_word = idx_q[BI_W +: WA_W];
    assign w_cur_bit  = BI_W'(WORD_W-1) - idx_q[BI_W-1:0];
    assign w_nxt_word = idx_d[BI_W +: WA_W];
    assign w_nxt_bit  = BI_W'(WORD_W-1) - idx_d[BI_W-1:0];
    assign w_nxt_cfg  = cfg_words[w_nxt_word];

    com_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk        (fw_axi_clk),
        .rst_n      (fw_rst_n),
        .i_clear    (op_code_w_reset),
        .i_load     (w_div_load),
        .i_load_val (w_div_val),
        .o_tick     (w_tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        h_d        = h_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        cap_d      = cap_q;
        w_div_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_code_w_execute) begin
                    n_d        = bit_count;
                    h_d        = (half_period == '0) ? CFG_HP_W'(1) : half_period;
                    idx_d      = '0;
                    done_d     = 1'b0;
                    w_div_load = 1'b1;
                    state_d    = (bit_count == '0) ? ST_LOAD : ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    cap_d[w_cur_word][w_cur_bit] = cfg_if.fw_config_out;
                    w_div_load = 1'b1;
                    state_d    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    idx_d      = idx_q + CNT_W'(1);
                    w_div_load = 1'b1;
                    state_d    = (idx_q + CNT_W'(1) == n_q) ? ST_LOAD : ST_LOW;
                end
            end
            ST_LOAD: begin
                if (w_tick) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (op_code_w_execute && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
        if (op_code_w_status_clear) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (op_code_w_reset) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            done_d     = 1'b0;
            ovr_d      = 1'b0;
            cap_d      = '0;
            w_div_load = 1'b0;
        end
    end

    // The load strobe phase spans two half periods.
    assign w_div_val = (state_d == ST_LOAD) ? {h_d, 1'b0} : {1'b0, h_d};

    // Pins are computed from the next state so they change on the same edge as the FSM.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        cclk_d  = (state_d == ST_HIGH);
        cload_d = (state_d == ST_LOAD);
        cin_d   = 1'b0;
        if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
            cin_d = w_nxt_cfg[w_nxt_bit];
        end
    end

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            h_q     <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            cclk_q  <= 1'b0;
            cin_q   <= 1'b0;
            cload_q <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            h_q     <= h_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            cclk_q  <= cclk_d;
            cin_q   <= cin_d;
            cload_q <= cload_d;
            cap_q   <= cap_d;
        end
    end

    assign cfg_if.fw_config_clk  = cclk_q;
    assign cfg_if.fw_config_in   = cin_q;
    assign cfg_if.fw_config_load = cload_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;
    assign rd_data = cap_q[rd_addr];

endmodule
`default_nettype wire
